// File: rtl/series_pkg.sv
// Shared definitions for the series-evaluation controller: state codes and
// the adder sign encoding.
package series_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_INIT  = 3'd1;
    localparam state_t S_LOAD  = 3'd2;
    localparam state_t S_MULT  = 3'd3;
    localparam state_t S_CHECK = 3'd4;
    localparam state_t S_ACC   = 3'd5;
    localparam state_t S_DONE  = 3'd6;

    // Value driven onto the adder carry-in for each term sign.
    localparam logic SIGN_ADD = 1'b0;
    localparam logic SIGN_SUB = 1'b1;

endpackage

// File: rtl/series_cnt.sv
// Up-counter with synchronous clear and enable; wraps to zero after MAX-1
// and flags the terminal value.
module series_cnt #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MAX - 1));

    // Count register: clear wins over increment, wrap at the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/series_ctrl_param.sv
// Controller for the iterative series datapath: per term, a chain of
// multiply passes (x path then coefficient path), a continue check and an
// add/sub accumulate. Strobes are Moore outputs of state and mult_cnt.
import series_pkg::*;

module series_ctrl_param #(
    parameter int N_TERMS     = 8,
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             mode,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             loadx,
    output logic             select,
    output logic             enc,
    output logic             counter_init,
    output logic             t_init,
    output logic             loadt,
    output logic             r_init,
    output logic             loadr,
    output logic             ci_adder,
    output logic [CNT_W-1:0] term_idx
);

    localparam int MW = $clog2(MULT_CYCLES);

    state_t          state, nstate;
    logic [MW-1:0]   mult_cnt;
    logic            mult_tc, term_tc;
    logic            sign, mode_r;
    logic            cnt_clr, mult_inc, term_inc;

    // An aborted cycle leaves every counter and the sign as they were.
    assign cnt_clr  = (state == S_INIT) && !abort;
    assign mult_inc = (state == S_MULT) && !abort;
    assign term_inc = (state == S_ACC)  && !abort;

    series_cnt #(.MAX(MULT_CYCLES), .W(MW)) u_mult_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(mult_inc),
        .cnt(mult_cnt), .tc(mult_tc)
    );

    series_cnt #(.MAX(N_TERMS), .W(CNT_W)) u_term_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(term_inc),
        .cnt(term_idx), .tc(term_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    // Next state; abort outranks everything outside IDLE.
    always_comb begin
        nstate = state;
        if (abort && state != S_IDLE) begin
            nstate = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) nstate = S_INIT;
                S_INIT:  if (!start) nstate = S_LOAD;
                S_LOAD:  nstate = S_MULT;
                S_MULT:  if (mult_tc) nstate = S_CHECK;
                S_CHECK: nstate = (!en || term_tc) ? S_DONE : S_ACC;
                S_ACC:   nstate = S_MULT;
                S_DONE:  nstate = S_IDLE;
                default: nstate = S_IDLE;
            endcase
        end
    end

    // Sign of the current term and the mode latched for this run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign   <= SIGN_ADD;
            mode_r <= 1'b0;
        end else if (cnt_clr) begin
            sign   <= SIGN_ADD;
            mode_r <= mode;
        end else if (term_inc && mode_r) begin
            sign   <= (sign == SIGN_ADD) ? SIGN_SUB : SIGN_ADD;
        end
    end

    // Moore strobe decode.
    always_comb begin
        ready        = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        loadx        = 1'b0;
        select       = 1'b0;
        enc          = 1'b0;
        counter_init = 1'b0;
        t_init       = 1'b0;
        loadt        = 1'b0;
        r_init       = 1'b0;
        loadr        = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            S_INIT: begin
                t_init       = 1'b1;
                r_init       = 1'b1;
                counter_init = 1'b1;
            end
            S_LOAD: loadx = 1'b1;
            S_MULT: begin
                loadt  = 1'b1;
                select = (mult_cnt >= MW'(MULT_CYCLES / 2));
                enc    = (mult_cnt >= MW'(MULT_CYCLES / 2));
            end
            S_ACC:  loadr = 1'b1;
            S_DONE: begin
                done = 1'b1;
                busy = 1'b0;
            end
            default: ;
        endcase
    end

    assign ci_adder = sign;

endmodule

// File: tb/tb_series_ctrl_param.sv
// Bench for series_ctrl_param: each run is expanded from the behavioural
// rules into an expected per-cycle trace (state kind, term, sign) together
// with the inputs to drive, then replayed against the DUT cycle by cycle.
module tb_series_ctrl_param;

    localparam int N  = 8;
    localparam int MC = 4;
    localparam int CW = 4;

    localparam int T_IDLE = 0, T_INIT = 1, T_LOAD = 2, T_MULT = 3,
                   T_CHECK = 4, T_ACC = 5, T_DONE = 6;

    typedef struct packed {
        logic start;
        logic en;
        logic mode;
        logic abort;
    } stim_t;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, en = 1'b0, mode = 1'b0, abort = 1'b0;
    logic ready, busy, done, loadx, select, enc, counter_init, t_init;
    logic loadt, r_init, loadr, ci_adder;
    logic [CW-1:0] term_idx;
    logic [15:0] obs;

    series_ctrl_param #(.N_TERMS(N), .MULT_CYCLES(MC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .mode(mode), .abort(abort),
        .ready(ready), .busy(busy), .done(done), .loadx(loadx), .select(select),
        .enc(enc), .counter_init(counter_init), .t_init(t_init), .loadt(loadt),
        .r_init(r_init), .loadr(loadr), .ci_adder(ci_adder), .term_idx(term_idx)
    );

    always #5 clk = ~clk;

    assign obs = {ready, busy, done, loadx, select, enc, counter_init, t_init,
                  loadt, r_init, loadr, ci_adder, term_idx};

    logic [15:0] exp_q[$];
    stim_t       stim_q[$];
    int          n_chk = 0, n_fail = 0;
    int          pos, ab_at, last_idx = 0;
    bit          cut, last_m = 1'b0;

    // observed tallies for the most recent replay
    int          cnt_loadr, cnt_enc, done_at, ci_hi;
    logic [6:0]  ci_seq;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected output vector for one cycle of a given kind.
    function automatic logic [15:0] ov(int st, int mc, int idx, bit m);
        logic rd, bz, dn, lx, sel, lt, ti, lr, ci;
        logic [CW-1:0] ix;
        rd = (st == T_IDLE);
        dn = (st == T_DONE);
        bz = !rd && !dn;
        lx = (st == T_LOAD);
        lt = (st == T_MULT);
        sel = lt && (mc >= MC / 2);
        ti = (st == T_INIT);
        lr = (st == T_ACC);
        ix = CW'(idx);
        ci = m && ix[0];
        return {rd, bz, dn, lx, sel, sel, ti, ti, lt, ti, lr, ci, ix};
    endfunction

    task automatic push(int st, int mc, int idx, bit m, logic s, logic e, logic md);
        stim_t x;
        if (cut) return;
        x.start = s; x.en = e; x.mode = md;
        x.abort = (st == T_IDLE) ? rb() : 1'b0;
        if (st != T_IDLE && pos == ab_at) begin
            x.abort = 1'b1;
            cut = 1'b1;
        end
        pos++;
        exp_q.push_back(ov(st, mc, idx, m));
        stim_q.push_back(x);
        last_idx = idx;
        last_m   = m;
    endtask

    // One run: idle gaps, start held `hold` cycles, en dropped at the CHECK
    // of term k (k<0: never), optional abort at trace position ab.
    task automatic run(bit md, int hold, int k, int ab, int gaps);
        cut = 1'b0; pos = 0; ab_at = ab;
        for (int g = 0; g < gaps; g++)
            push(T_IDLE, 0, last_idx, last_m, 1'b0, rb(), rb());
        push(T_IDLE, 0, last_idx, last_m, 1'b1, rb(), rb());
        for (int h = 0; h < hold; h++)
            push(T_INIT, 0, (h == 0) ? last_idx : 0, (h == 0) ? last_m : md,
                 (h < hold - 1), rb(), md);
        push(T_LOAD, 0, 0, md, rb(), rb(), rb());
        for (int j = 0; j < N; j++) begin
            for (int c = 0; c < MC; c++)
                push(T_MULT, c, j, md, rb(), rb(), rb());
            push(T_CHECK, 0, j, md, rb(), (j == k) ? 1'b0 : 1'b1, rb());
            if (j == k || j == N - 1) begin
                push(T_DONE, 0, j, md, rb(), rb(), rb());
                break;
            end
            push(T_ACC, 0, j, md, rb(), rb(), rb());
        end
    endtask

    // Replay up to `lim` queued cycles (all if negative), then drop the rest.
    task automatic play(int lim);
        int i;
        cnt_loadr = 0; cnt_enc = 0; done_at = -1; ci_hi = 0; ci_seq = '0;
        i = 0;
        while (exp_q.size() > 0 && (lim < 0 || i < lim)) begin
            logic [15:0] e;
            stim_t x;
            e = exp_q.pop_front();
            x = stim_q.pop_front();
            n_chk++;
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL step%0d got=%h expected=%h", i, obs, e);
            end
            if (loadr) begin
                cnt_loadr++;
                ci_seq = {ci_seq[5:0], ci_adder};
            end
            if (enc) cnt_enc++;
            if (ci_adder) ci_hi++;
            if (done && done_at < 0) done_at = i;
            start = x.start; en = x.en; mode = x.mode; abort = x.abort;
            @(posedge clk); #1;
            i++;
        end
        exp_q.delete();
        stim_q.delete();
    endtask

    task automatic chk(string tag, int got, int want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        n_chk++;
        assert (obs === ov(T_IDLE, 0, 0, 1'b0)) else begin
            n_fail++;
            $error("FAIL reset got=%h expected=%h", obs, ov(T_IDLE, 0, 0, 1'b0));
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // full-length run, add only: INIT at 0, LOAD at 1, done at 49
        run(1'b0, 1, -1, -1, 0);
        play(-1);
        chk("done_cycle", done_at - 1, 49);
        chk("loadr_cnt", cnt_loadr, 7);
        chk("enc_cnt", cnt_enc, 16);
        chk("ci_never", ci_hi, 0);

        // alternating signs over the seven accumulates
        run(1'b1, 1, -1, -1, 1);
        play(-1);
        chk("ci_seq", int'(ci_seq), int'(7'b0101010));

        // en withdrawn at the third CHECK
        run(1'b0, 1, 2, -1, 0);
        play(-1);
        chk("early_loadr", cnt_loadr, 2);

        // start held for five cycles
        run(1'b0, 5, 1, -1, 0);
        play(-1);

        // abort in MULT of term 3, then a clean restart
        run(1'b1, 1, -1, 22, 0);
        play(-1);
        chk("abort_nodone", done_at, -1);
        run(1'b0, 2, 4, -1, 0);
        play(-1);

        // randomized runs
        for (int r = 0; r < 14; r++) begin
            int gp, ab;
            gp = $urandom_range(0, 2);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(gp + 1, 45) : -1;
            run(rb(), $urandom_range(1, 4),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1,
                ab, gp);
            play(-1);
        end

        // reset in the middle of a run
        run(1'b1, 1, -1, -1, 0);
        play(20);
        rst = 1'b1;
        start = 1'b0; abort = 1'b0;
        #1;
        n_chk++;
        assert (obs === ov(T_IDLE, 0, 0, 1'b0)) else begin
            n_fail++;
            $error("FAIL midrst got=%h expected=%h", obs, ov(T_IDLE, 0, 0, 1'b0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_idx = 0; last_m = 1'b0;
        run(1'b0, 1, 3, -1, 1);
        push(T_IDLE, 0, last_idx, last_m, 1'b0, 1'b0, 1'b0);
        play(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
